fpu_divider: RTL and testbench

Multi-cycle IEEE-754 single-precision divider, op = a / b. It is the inverse-operation companion to the FP32 multiplier and uses the same clk / a / b / op / finish interface plus an explicit start/busy handshake. It performs iterative radix-2 restoring mantissa division and rounds round-to-nearest-even. Special-case encodings match the multiplier so both units can sit behind one FPU result mux.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fp_classify.sv | 20 ++
 rtl/fpu_divider.sv | 149 ++++++++++++++
 tb/tb_fpu_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the divider and multiplier: encodings, field
// widths, operand layout and the divider sequencer states.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] QNAN_NEG = 32'hFFC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 operand classifier; denormals report as zero (DAZ).
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  fp32_t f;
  logic  unused_sign;

  assign f           = x;
  assign unused_sign = f.sign;
  assign is_nan      = (&f.exp) & (|f.frac);
  assign is_inf      = (&f.exp) & ~(|f.frac);
  assign is_zero     = ~(|f.exp);

endmodule

// File: rtl/fpu_divider.sv
// Multi-cycle FP32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, round-to-nearest-even, DAZ inputs and FTZ results.
module fpu_divider #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] op,
  output logic        finish
);
  import fpu_pkg::*;

  localparam int MANT_W = FRAC_W + 1;
  localparam int REM_W  = FRAC_W + 2;
  localparam int ITERS  = FRAC_W + 2;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(ITERS);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_ZERO = E_W'(0);
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);

  div_state_t              state;
  fp32_t                   a_r, b_r;
  logic [MANT_W-1:0]       mb;
  logic [REM_W-1:0]        rem;
  logic [FRAC_W:0]         q;
  logic signed [E_W-1:0]   e;
  logic [CNT_W-1:0]        cnt;
  logic                    sign;

  logic                    a_nan, a_inf, a_zero;
  logic                    b_nan, b_inf, b_zero;
  logic                    s_w, ge;
  logic [MANT_W-1:0]       ma_w, mb_w, diff;
  logic signed [E_W-1:0]   e_w;

  fp_classify u_cls_a (.x(a_r), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
  fp_classify u_cls_b (.x(b_r), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

  assign s_w  = a_r.sign ^ b_r.sign;
  assign ma_w = {1'b1, a_r.frac};
  assign mb_w = {1'b1, b_r.frac};
  assign e_w  = E_W'(a_r.exp) - E_W'(b_r.exp) + E_BIAS;
  assign ge   = ({1'b0, mb} <= rem);
  // When rem >= mb the difference is below mb, so the low bits carry it exactly.
  assign diff = rem[REM_W-2:0] - mb;

  // q holds fraction + guard; the leading quotient bit is always 1 and drops off.
  function automatic logic [31:0] round_pack(input logic                  s,
                                             input logic signed [E_W-1:0] e_in,
                                             input logic [FRAC_W:0]       qv,
                                             input logic                  sticky);
    logic [FRAC_W:0]       fr;
    logic signed [E_W-1:0] ex;
    logic                  up;
    up = qv[0] & (sticky | qv[1]);
    fr = {1'b0, qv[FRAC_W:1]} + {{FRAC_W{1'b0}}, up};
    ex = e_in;
    if (fr[FRAC_W]) ex = ex + E_ONE;
    if (ex >= E_MAX)       round_pack = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (ex <= E_ZERO) round_pack = {s, {(EXP_W+FRAC_W){1'b0}}};
    else                   round_pack = {s, ex[EXP_W-1:0], fr[FRAC_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      finish <= 1'b0;
      op     <= '0;
      a_r    <= '0;
      b_r    <= '0;
      mb     <= '0;
      rem    <= '0;
      q      <= '0;
      e      <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          sign <= s_w;
          if (a_nan | b_nan) begin
            op <= QNAN;
            finish <= 1'b1;
            state  <= S_DONE;
          end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
            op <= QNAN_NEG;
            finish <= 1'b1;
            state  <= S_DONE;
          end else if (a_inf | b_zero) begin
            op <= {s_w, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            finish <= 1'b1;
            state  <= S_DONE;
          end else if (a_zero | b_inf) begin
            op <= {s_w, {(EXP_W+FRAC_W){1'b0}}};
            finish <= 1'b1;
            state  <= S_DONE;
          end else begin
            // Pre-normalise so the quotient lands in [1,2).
            mb    <= mb_w;
            q     <= '0;
            cnt   <= '0;
            state <= S_DIVIDE;
            if (ma_w < mb_w) begin
              rem <= {ma_w, 1'b0};
              e   <= e_w - E_ONE;
            end else begin
              rem <= {1'b0, ma_w};
              e   <= e_w;
            end
          end
        end
        S_DIVIDE: begin
          q   <= {q[FRAC_W-1:0], ge};
          rem <= ge ? {diff, 1'b0} : {rem[REM_W-2:0], 1'b0};
          if (cnt == CNT_W'(ITERS - 1)) state <= S_ROUND;
          else                          cnt   <= cnt + CNT_W'(1);
        end
        S_ROUND: begin
          op     <= round_pack(sign, e, q, |rem);
          finish <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divider.sv
// Scoreboard bench for fpu_divider: an exact integer-quotient reference model
// predicts each result and its finish cycle; a negedge monitor checks them.
module tb_fpu_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] op;
  logic        finish;

  fpu_divider dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .op(op), .finish(finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op;
    int          fin;
  } exp_t;

  exp_t        sbq[$];
  int          acc_edge  = -100;
  int          free_edge = 0;
  logic [31:0] exp_hold  = '0;
  bit          mon_en    = 1'b0;
  bit          mon_busy;
  exp_t        mon_e;
  int          n_checks  = 0;
  int          n_pass    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // Exact quotient with explicit round-half-to-even on the remainder.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          output bit special);
    bit     s  = x[31] ^ y[31];
    int     ex = int'(x[30:23]);
    int     ey = int'(y[30:23]);
    bit     xn = (ex == 255) && (x[22:0] != 0);
    bit     yn = (ey == 255) && (y[22:0] != 0);
    bit     xi = (ex == 255) && (x[22:0] == 0);
    bit     yi = (ey == 255) && (y[22:0] == 0);
    bit     xz = (ex == 0);
    bit     yz = (ey == 0);
    longint ma, mb, n, m, r;
    int     e;
    special = 1'b1;
    if (xn || yn)                   return 32'h7FC00000;
    if ((xi && yi) || (xz && yz))   return 32'hFFC00000;
    if (xi || yz)                   return {s, 8'hFF, 23'h0};
    if (xz || yi)                   return {s, 31'h0};
    special = 1'b0;
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    e  = ex - ey + 127;
    if (ma < mb) begin
      n = ma << 24;
      e = e - 1;
    end else begin
      n = ma << 23;
    end
    m = n / mb;
    r = n - m * mb;
    if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
    if (m == 64'd16777216) begin
      m = 64'd8388608;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r = $urandom();
    int          k = $urandom_range(0, 15);
    case (k)
      0: r[30:0]  = '0;
      1: r[30:23] = 8'h00;
      2: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3: r[30:23] = 8'hFF;
      4: r[30:23] = 8'($urandom_range(240, 254));
      5: r[30:23] = 8'($urandom_range(1, 15));
      6: begin
        r[15:0] = '0;
        if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'd127;
      end
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'd127;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one cycle; if the DUT is idle at the coming edge a start is accepted.
  task automatic offer(input logic [31:0] av, input logic [31:0] bv, input bit st,
                       input bit use_tab, input logic [31:0] tab_exp);
    bit          sp;
    logic [31:0] ev;
    a     = av;
    b     = bv;
    start = st;
    if (st && (cyc + 1 >= free_edge)) begin
      ev = ref_div(av, bv, sp);
      if (use_tab) ev = tab_exp;
      acc_edge  = cyc + 1;
      sbq.push_back('{op: ev, fin: acc_edge + (sp ? 1 : 27)});
      free_edge = acc_edge + (sp ? 3 : 29);
    end
    step();
  endtask

  task automatic idle_until_free();
    while (cyc + 1 < free_edge) offer(rand_fp(), rand_fp(), 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst       = 1'b0;
    sbq.delete();
    acc_edge  = -100;
    free_edge = cyc + 1;
    exp_hold  = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_busy = (cyc >= acc_edge) && (cyc <= free_edge - 2);
      chk("busy", {31'b0, busy}, {31'b0, mon_busy});
      if (finish) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL finish_unexpected: got finish=1 op=%h, expected no finish (cycle %0d)", op, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("op", op, mon_e.op);
          chk("finish_cycle", cyc, mon_e.fin);
          exp_hold = mon_e.op;
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].fin) begin
        mon_e = sbq.pop_front();
        n_checks++;
        $display("FAIL finish_missing: got no finish, expected finish at cycle %0d with op %h", mon_e.fin, mon_e.op);
        exp_hold = mon_e.op;
      end
      if (!mon_busy) chk("op_hold", op, exp_hold);
    end
  end

  logic [31:0] dir_a [11] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                              32'h00000000, 32'h7FC00001, 32'h7F800000, 32'h3F800000,
                              32'h7F000000, 32'h00800000, 32'h00400000};
  logic [31:0] dir_b [11] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h80000000,
                              32'h00000000, 32'h3F800000, 32'hFF800000, 32'h7F800000,
                              32'h00800000, 32'h7F000000, 32'h3F800000};
  logic [31:0] dir_q [11] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
                              32'hFFC00000, 32'h7FC00000, 32'hFFC00000, 32'h00000000,
                              32'h7F800000, 32'h00000000, 32'h00000000};

  initial begin
    step();
    step();
    rst       = 1'b0;
    free_edge = cyc + 1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_finish", {31'b0, finish}, 32'd0);
    chk("reset_op", op, 32'h0);
    mon_en = 1'b1;

    // Directed values with operands scrambled while the unit is busy.
    for (int i = 0; i < 11; i++) begin
      offer(dir_a[i], dir_b[i], 1'b1, 1'b1, dir_q[i]);
      idle_until_free();
    end

    // Abort mid-operation; reset is sampled on the 10th edge of the operation.
    offer(32'h40C00000, 32'h40000000, 1'b1, 1'b1, 32'h40400000);
    repeat (8) offer(rand_fp(), rand_fp(), 1'b0, 1'b0, '0);
    do_reset();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_op", op, 32'h0);
    chk("abort_finish", {31'b0, finish}, 32'd0);
    offer(32'hC0000000, 32'h3F000000, 1'b1, 1'b1, 32'hC0800000);
    idle_until_free();

    // start held high, operands changing every cycle.
    for (int i = 0; i < 600; i++) offer(rand_fp(), rand_fp(), 1'b1, 1'b0, '0);

    // Sparse random start pulses, some landing while busy.
    for (int i = 0; i < 3000; i++)
      offer(rand_fp(), rand_fp(), ($urandom_range(0, 3) == 0), 1'b0, '0);

    while (cyc < free_edge) offer(rand_fp(), rand_fp(), 1'b0, 1'b0, '0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
